// File: rtl/maze_pkg.sv
// Shared types and constants for the maze pixel pipeline.
package maze_pkg;

  localparam int unsigned MAZE_W_DEF     = 80;
  localparam int unsigned MAZE_H_DEF     = 60;
  localparam int unsigned CELL_SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    FLOOR = 2'd0,
    WALL  = 2'd1,
    EXIT  = 2'd2,
    START = 2'd3
  } cell_code_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t COL_WALL   = '{r: 4'h0, g: 4'h0, b: 4'hF};
  localparam rgb_t COL_FLOOR  = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t COL_EXIT   = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb_t COL_START  = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t COL_PLAYER = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb_t COL_GRID   = '{r: 4'h4, g: 4'h4, b: 4'h4};

endpackage

// File: rtl/maze_blink_ctr.sv
// Vsync assertion-edge detector, frame counter and exit blink phase.
module maze_blink_ctr
  import maze_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned SYNC_POL     = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic blink_on,
  output logic frame_start_c
);

  localparam int unsigned CW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic        SYNC_ACT = 1'(SYNC_POL);

  logic          vs_prev;
  logic [CW-1:0] frame_cnt;

  // One-cycle pulse when vsync_in moves into its active level.
  assign frame_start_c = (vsync_in == SYNC_ACT) && (vs_prev != SYNC_ACT);

  // Previous vsync level; starts inactive so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_prev <= ~SYNC_ACT;
    else        vs_prev <= vsync_in;
  end

  // Count frames and flip the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start_c) begin
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/maze_pixel_fetch.sv
// Pixel -> maze cell -> ROM read -> colour pipeline, 3 clk latency with aligned syncs.
// Optional MAZE_GRID_EN: floor pixels on a cell's first row/column render as grid lines.
module maze_pixel_fetch
  import maze_pkg::*;
#(
  parameter int unsigned MAZE_W       = MAZE_W_DEF,
  parameter int unsigned MAZE_H       = MAZE_H_DEF,
  parameter int unsigned CELL_SHIFT   = CELL_SHIFT_DEF,
  parameter int unsigned ROM_W        = 16,
  parameter int unsigned ASIZE        = $clog2(MAZE_W * MAZE_H),
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned SYNC_POL     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             pix_active,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [6:0]       player_cx,
  input  logic [5:0]       player_cy,
  output logic             rom_en,
  output logic [ASIZE-1:0] rom_addr,
  input  logic [ROM_W-1:0] rom_dout,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync
);

  localparam int unsigned PW       = 10;
  localparam logic        SYNC_INA = ~(1'(SYNC_POL));

  logic [PW-1:0]    col, row;
  logic             in_maze_c, hit_c;
  logic [6:0]       shadow_cx;
  logic [5:0]       shadow_cy;
  logic             blink_on, frame_start_c;
  logic [ASIZE-1:0] s1_addr;
  logic             s1_valid, s1_hit, s1_hs, s1_vs;
  logic             s2_valid, s2_hit, s2_hs, s2_vs;
  rgb_t             colour, floor_colour;
  logic             unused_rom_bits;
`ifdef MAZE_GRID_EN
  logic [CELL_SHIFT-1:0] s1_ox, s1_oy, s2_ox, s2_oy;
`endif

  // Only the cell code is meaningful in the ROM word.
  assign unused_rom_bits = ^rom_dout[ROM_W-1:2];

  maze_blink_ctr #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .SYNC_POL     (SYNC_POL)
  ) u_blink (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync_in      (vsync_in),
    .blink_on      (blink_on),
    .frame_start_c (frame_start_c)
  );

  // Cell coordinates, visibility and player match for the incoming pixel.
  assign col       = pix_x >> CELL_SHIFT;
  assign row       = pix_y >> CELL_SHIFT;
  assign in_maze_c = pix_active && (32'(col) < MAZE_W) && (32'(row) < MAZE_H);
  assign hit_c     = (PW'(shadow_cx) == col) && (PW'(shadow_cy) == row);

  // Player position is sampled only at frame start to avoid tearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_cx <= '0;
      shadow_cy <= '0;
    end else if (frame_start_c) begin
      shadow_cx <= player_cx;
      shadow_cy <= player_cy;
    end
  end

  // S1: address and sideband; drives the ROM port directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_addr  <= '0;
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_hs    <= SYNC_INA;
      s1_vs    <= SYNC_INA;
`ifdef MAZE_GRID_EN
      s1_ox    <= '0;
      s1_oy    <= '0;
`endif
    end else begin
      s1_addr  <= ASIZE'(32'(row) * MAZE_W + 32'(col));
      s1_valid <= in_maze_c;
      s1_hit   <= in_maze_c && hit_c;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
`ifdef MAZE_GRID_EN
      s1_ox    <= pix_x[CELL_SHIFT-1:0];
      s1_oy    <= pix_y[CELL_SHIFT-1:0];
`endif
    end
  end

  assign rom_en   = s1_valid;
  assign rom_addr = s1_addr;

  // S2: sideband waits alongside the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_hs    <= SYNC_INA;
      s2_vs    <= SYNC_INA;
`ifdef MAZE_GRID_EN
      s2_ox    <= '0;
      s2_oy    <= '0;
`endif
    end else begin
      s2_valid <= s1_valid;
      s2_hit   <= s1_hit;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
`ifdef MAZE_GRID_EN
      s2_ox    <= s1_ox;
      s2_oy    <= s1_oy;
`endif
    end
  end

  // Floor shade, with grid lines on the first row/column of each cell when enabled.
`ifdef MAZE_GRID_EN
  assign floor_colour = ((s2_ox == '0) || (s2_oy == '0)) ? COL_GRID : COL_FLOOR;
`else
  assign floor_colour = COL_FLOOR;
`endif

  // Colour priority: invisible, player, then cell code.
  always_comb begin
    colour = COL_BLACK;
    if (s2_valid) begin
      if (s2_hit) begin
        colour = COL_PLAYER;
      end else begin
        case (cell_code_t'(rom_dout[1:0]))
          WALL:    colour = COL_WALL;
          EXIT:    colour = blink_on ? COL_EXIT : COL_BLACK;
          START:   colour = COL_START;
          default: colour = floor_colour;
        endcase
      end
    end
  end

  // S3: registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= SYNC_INA;
      vga_vsync <= SYNC_INA;
    end else begin
      vga_r     <= colour.r;
      vga_g     <= colour.g;
      vga_b     <= colour.b;
      vga_hsync <= s2_hs;
      vga_vsync <= s2_vs;
    end
  end

endmodule

// File: tb/tb_maze_pixel_fetch.sv
// Directed self-checking bench for maze_pixel_fetch with a registered ROM model.
module tb_maze_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        pix_active = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [6:0]  player_cx = '0;
  logic [5:0]  player_cy = '0;
  logic        rom_en;
  logic [12:0] rom_addr;
  logic [15:0] rom_dout = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync;
  logic [11:0] rgb;

  logic [15:0] mem [0:4799];

  int n_checks = 0;
  int n_fail   = 0;

  maze_pixel_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_active (pix_active),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .player_cx  (player_cx),
    .player_cy  (player_cy),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync)
  );

  assign rgb = {vga_r, vga_g, vga_b};

  always #5 clk = ~clk;

  // Registered-read ROM port
  always @(posedge clk) begin
    if (rom_en && (int'(rom_addr) < 4800)) rom_dout <= mem[int'(rom_addr)];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic act);
    pix_x      = 10'(x);
    pix_y      = 10'(y);
    pix_active = act;
  endtask

  task automatic fetch(input string tag, input int x, input int y, input logic exp_en,
                       input int exp_addr, input logic [11:0] exp_rgb);
    drive(x, y, 1'b1);
    tick();
    check({tag, "_en"}, 32'(rom_en), 32'(exp_en));
    if (exp_en) check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    drive(0, 0, 1'b0);
    tick();
    tick();
    check({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] hs_pat;
    logic [15:0] vs_pat;
    int          xs [3];
    logic [11:0] exp_seq [3];

    for (int i = 0; i < 4800; i++) mem[i] = {14'h2A5B, 2'd0};
    mem[0]      = {14'h1111, 2'd1};  // (0,0) wall
    mem[80 + 2] = {14'h0F0F, 2'd1};  // (2,1) wall
    mem[80 + 1] = {14'h3333, 2'd3};  // (1,1) start
    mem[405]    = {14'h0001, 2'd2};  // (5,5) exit

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_en",    32'(rom_en),    32'd0);
    check("rst_addr",  32'(rom_addr),  32'd0);
    check("rst_rgb",   32'(rgb),       32'h000);
    check("rst_hsync", 32'(vga_hsync), 32'd1);
    check("rst_vsync", 32'(vga_vsync), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Shadow player resets to (0,0): cell (0,0) shows the player
    fetch("player_at_reset", 3, 5, 1'b1, 0, 12'hF00);

    // Move player off-screen-area cell, then the wall shows
    player_cx = 7'd70;
    player_cy = 6'd50;
    vsync_pulse();
    fetch("wall_00", 3, 5, 1'b1, 0, 12'h00F);

    // Last cell then first column beyond the maze, back to back
    drive(639, 479, 1'b1);
    tick();
    check("last_en",   32'(rom_en),   32'd1);
    check("last_addr", 32'(rom_addr), 32'd4799);
    drive(640, 479, 1'b1);
    tick();
    check("x640_en", 32'(rom_en), 32'd0);
    drive(0, 0, 1'b0);
    tick();
    check("last_rgb", 32'(rgb), 32'hFFF);
    tick();
    check("x640_rgb", 32'(rgb), 32'h000);

    fetch("y480", 100, 480, 1'b0, 0, 12'h000);

    // Consecutive pixels: one read per clock, no bubbles
    xs[0] = 1;  xs[1] = 9;  xs[2] = 17;
    exp_seq[0] = 12'h00F; exp_seq[1] = 12'hFFF; exp_seq[2] = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(xs[i], 1, 1'b1);
      else       drive(0, 0, 1'b0);
      tick();
      if (i < 3) begin
        check("b2b_en",   32'(rom_en),   32'd1);
        check("b2b_addr", 32'(rom_addr), 32'(xs[i] >> 3));
      end
      if (i >= 2) check("b2b_rgb", 32'(rgb), 32'(exp_seq[i-2]));
    end

    // Sync patterns with blanking: exactly 3 clk delay, colour stays black
    hs_pat = 16'hB2E7;
    vs_pat = 16'h6F39;
    drive(0, 0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      hsync_in = (i < 16) ? hs_pat[i] : 1'b1;
      vsync_in = (i < 16) ? vs_pat[i] : 1'b1;
      tick();
      if (i >= 2) begin
        check("sync_h",   32'(vga_hsync), 32'(hs_pat[i-2]));
        check("sync_v",   32'(vga_vsync), 32'(vs_pat[i-2]));
        check("sync_rgb", 32'(rgb),       32'h000);
      end
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) tick();

    // Player change mid-frame takes effect only after the next vsync edge
    player_cx = 7'd2;
    player_cy = 6'd1;
    repeat (2) tick();
    fetch("player_pending", 16, 8, 1'b1, 82, 12'h00F);
    vsync_pulse();
    fetch("player_tl",  16, 8,  1'b1, 82, 12'hF00);
    fetch("player_br",  23, 15, 1'b1, 82, 12'hF00);
    fetch("start_11",   8,  8,  1'b1, 81, 12'hFF0);
    fetch("floor_31",   25, 9,  1'b1, 83, 12'hFFF);

    // Asynchronous reset mid-line
    player_cx = 7'd0;
    player_cy = 6'd0;
    drive(25, 9, 1'b1);
    hsync_in = 1'b0;
    repeat (4) tick();
    check("pre_rst_rgb",   32'(rgb),       32'hFFF);
    check("pre_rst_hsync", 32'(vga_hsync), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb",   32'(rgb),       32'h000);
    check("async_rst_hsync", 32'(vga_hsync), 32'd1);
    check("async_rst_vsync", 32'(vga_vsync), 32'd1);
    check("async_rst_en",    32'(rom_en),    32'd0);
    check("async_rst_addr",  32'(rom_addr),  32'd0);
    drive(0, 0, 1'b0);
    hsync_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Exit blink: counter restarted by reset, 30 frames on, 30 off, then on
    for (int f = 0; f <= 60; f++) begin
      fetch("blink", 42, 42, 1'b1, 405, (f < 30 || f == 60) ? 12'h0F0 : 12'h000);
      vsync_pulse();
    end

    // Grid lines on floor cell (1,0)
`ifdef MAZE_GRID_EN
    fetch("grid_edge", 8, 3, 1'b1, 1, 12'h444);
`else
    fetch("grid_edge", 8, 3, 1'b1, 1, 12'hFFF);
`endif
    fetch("grid_inner", 9, 3, 1'b1, 1, 12'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
